// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch stage. Returns one 32-bit fetch
//   word per cycle at halfword granularity (RV32C-friendly). It also contains
//   a byte-serial program loader that assembles little-endian words and writes
//   them from word 0 upward, stalling fetch while it runs.
//
// Ports
//   clk             : single clock, all state on the rising edge
//   reset           : synchronous, active-high
//   address         : fetch byte address (bit 0 ignored, bit 1 = halfword offset)
//   read_en         : fetch request, sampled at the clock edge
//   data            : registered fetch word (1-cycle latency)
//   data_valid      : data answers the previous cycle's request
//   busy            : loader active, fetch returns NOP_WORD with data_valid=0
//   load_start      : one-cycle pulse that starts a load (ignored unless idle)
//   load_len        : number of words to load, sampled with load_start
//   load_byte_valid : load_byte carries a program byte this cycle
//   load_byte       : program byte, least significant byte of each word first
//   load_done       : one-cycle pulse when a load completes
//   words_loaded    : words written by the current or last load
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_en,
   output logic [31:0] data,
   output logic        data_valid,
   output logic        busy,
   input  logic        load_start,
   input  logic [15:0] load_len,
   input  logic        load_byte_valid,
   input  logic [7:0]  load_byte,
   output logic        load_done,
   output logic [15:0] words_loaded
);

   localparam int AW         = $clog2(DEPTH_WORDS);
   localparam int BW         = (AW > 1) ? AW - 1 : 1;
   localparam int BANK_WORDS = DEPTH_WORDS / 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t      state;
   logic [15:0] len_q;
   logic [15:0] ptr;
   logic [1:0]  bcnt;
   logic [23:0] asm_q;     // lower three bytes; the 4th byte goes straight to memory

   // Word w lives in even_mem[w/2] when w is even, odd_mem[w/2] when odd, so
   // any two consecutive words sit in different banks and read together.
   logic [31:0] even_mem [BANK_WORDS];
   logic [31:0] odd_mem  [BANK_WORDS];

   // ---------------------------------------------------------------- fetch path
   logic [29:0]   w;
   logic [AW-1:0] w_lo;
   logic [BW-1:0] even_idx;
   logic [BW-1:0] odd_idx;
   logic          in_range;
   logic          last_word;
   logic [31:0]   even_rd;
   logic [31:0]   odd_rd;
   logic [31:0]   lo_word;
   logic [31:0]   hi_word;
   logic [15:0]   hi_half;
   logic [31:0]   rd_word;
   logic          unused_addr_bit;

   assign unused_addr_bit = address[0];
   assign w         = address[31:2];
   assign w_lo      = w[AW-1:0];
   assign in_range  = {2'b00, w} < 32'(DEPTH_WORDS);
   assign last_word = (w_lo == AW'(DEPTH_WORDS - 1));

   // The odd bank always supplies whichever of w / w+1 is odd; the even bank
   // index steps forward by one when w itself is odd.
   assign odd_idx  = BW'(w_lo >> 1);
   assign even_idx = odd_idx + BW'(w_lo[0]);
   assign even_rd  = even_mem[even_idx];
   assign odd_rd   = odd_mem[odd_idx];
   assign lo_word  = w_lo[0] ? odd_rd  : even_rd;   // mem[w]
   assign hi_word  = w_lo[0] ? even_rd : odd_rd;    // mem[w+1]

   // No wrap past the top word: the missing upper half reads as c.nop.
   assign hi_half  = last_word ? 16'h0001 : hi_word[15:0];
   assign rd_word  = !in_range  ? NOP_WORD :
                     address[1] ? {hi_half, lo_word[31:16]} : lo_word;

   // ---------------------------------------------------------------- load path
   logic        busy_next;
   logic        byte_take;
   logic        word_write;
   logic        wr_in_range;
   logic [BW-1:0] wr_idx;
   logic [31:0] wr_word;

   // busy covers every non-idle state plus one trailing cycle after DONE, so
   // it equals "loader not idle now, or starting now" evaluated one edge early.
   assign busy_next   = (state != S_IDLE) || load_start;
   assign byte_take   = (state == S_LOAD) && (words_loaded != len_q) && load_byte_valid;
   assign word_write  = byte_take && (bcnt == 2'd3) && !reset;
   assign wr_in_range = {16'h0000, ptr} < 32'(DEPTH_WORDS);
   assign wr_idx      = BW'(ptr[AW-1:0] >> 1);
   assign wr_word     = {load_byte, asm_q};

   // NOTE: memory arrays get no reset branch; contents survive reset and a
   // reset would also prevent mapping onto RAM resources.
   always_ff @(posedge clk) begin
      if (word_write && wr_in_range) begin
         if (ptr[0]) odd_mem[wr_idx]  <= wr_word;
         else        even_mem[wr_idx] <= wr_word;
      end
   end

   // ------------------------------------------------------------- fetch output
   // Uses busy_next so data/data_valid are already blanked in the first busy
   // cycle; the arrays are read before the same-edge write lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= NOP_WORD;
         data_valid <= 1'b0;
      end else if (busy_next) begin
         data       <= NOP_WORD;
         data_valid <= 1'b0;
      end else if (read_en) begin
         data       <= rd_word;
         data_valid <= 1'b1;
      end else begin
         data_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------- loader FSM
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         len_q        <= '0;
         ptr          <= '0;
         bcnt         <= '0;
         asm_q        <= '0;
         busy         <= 1'b0;
         load_done    <= 1'b0;
         words_loaded <= '0;
      end else begin
         busy      <= busy_next;
         load_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_start) begin
                  len_q        <= load_len;
                  ptr          <= '0;
                  bcnt         <= '0;
                  words_loaded <= '0;
                  if (load_len == 16'd0) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (words_loaded == len_q) begin
                  state     <= S_DONE;
                  load_done <= 1'b1;
               end else if (load_byte_valid) begin
                  case (bcnt)
                     2'd0:    asm_q[7:0]   <= load_byte;
                     2'd1:    asm_q[15:8]  <= load_byte;
                     2'd2:    asm_q[23:16] <= load_byte;
                     default: ;
                  endcase
                  if (bcnt == 2'd3) begin
                     ptr          <= ptr + 16'd1;
                     words_loaded <= words_loaded + 16'd1;
                  end
                  bcnt <= bcnt + 2'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Self-checking bench for imem_responder. A timeline model (word array plus
//   byte queue and the edge numbers at which a load finishes) predicts every
//   output after every clock edge; a compare process checks the DUT against it
//   each cycle. Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk             = 1'b0;
   logic        reset           = 1'b1;
   logic [31:0] address         = '0;
   logic        read_en         = 1'b0;
   logic        load_start      = 1'b0;
   logic [15:0] load_len        = '0;
   logic        load_byte_valid = 1'b0;
   logic [7:0]  load_byte       = '0;
   logic [31:0] data;
   logic        data_valid;
   logic        busy;
   logic        load_done;
   logic [15:0] words_loaded;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
      .clk             (clk),
      .reset           (reset),
      .address         (address),
      .read_en         (read_en),
      .data            (data),
      .data_valid      (data_valid),
      .busy            (busy),
      .load_start      (load_start),
      .load_len        (load_len),
      .load_byte_valid (load_byte_valid),
      .load_byte       (load_byte),
      .load_done       (load_done),
      .words_loaded    (words_loaded)
   );

   int tests    = 0;
   int fails    = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   bit noise    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   logic [31:0] mm [DEPTH];
   logic [7:0]  bq [$];
   longint      cyc         = 0;
   bit          m_loading   = 1'b0;
   int          m_len       = 0;
   int          m_words     = 0;
   longint      m_done_edge = -10;   // edge at which the DONE cycle begins
   logic [31:0] e_data      = NOP;
   logic        e_valid     = 1'b0;
   logic        e_busy      = 1'b0;
   logic        e_done      = 1'b0;
   logic [15:0] e_words     = '0;

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      int unsigned w;
      logic [15:0] hi;
      w = {2'b00, a[31:2]};
      if (w >= DEPTH) return NOP;
      if (a[1] == 1'b0) return mm[w];
      if (w == DEPTH - 1) hi = 16'h0001;
      else                hi = mm[w + 1][15:0];
      return {hi, mm[w][31:16]};
   endfunction

   always @(posedge clk) begin : model_p
      logic [31:0] fw;
      bit          started;
      fw      = fetch_word(address);   // memory as it was before this edge
      started = 1'b0;
      if (reset) begin
         m_loading   = 1'b0;
         m_words     = 0;
         m_done_edge = -10;
         bq.delete();
         e_data  = NOP;
         e_valid = 1'b0;
         e_busy  = 1'b0;
         e_done  = 1'b0;
         e_words = '0;
      end else begin
         if (m_loading && load_byte_valid) begin
            bq.push_back(load_byte);
            if (bq.size() == 4) begin
               if (m_words < DEPTH) mm[m_words] = {bq[3], bq[2], bq[1], bq[0]};
               bq.delete();
               m_words++;
               if (m_words == m_len) begin
                  m_loading   = 1'b0;
                  m_done_edge = cyc + 1;
               end
            end
         end
         // A start is honoured only once the previous load's DONE cycle is over.
         if (load_start && !m_loading && cyc >= m_done_edge + 2) begin
            started = 1'b1;
            m_len   = int'(load_len);
            m_words = 0;
            bq.delete();
            if (load_len == 16'd0) m_done_edge = cyc;
            else                   m_loading   = 1'b1;
         end
         e_busy  = started || m_loading || (cyc <= m_done_edge + 1);
         e_done  = (cyc == m_done_edge);
         e_words = m_words[15:0];
         if (e_busy) begin
            e_data  = NOP;
            e_valid = 1'b0;
         end else if (read_en) begin
            e_data  = fw;
            e_valid = 1'b1;
         end else begin
            e_valid = 1'b0;
         end
      end
      cyc++;
   end

   // -------------------------------------------------------- compare process
   always @(posedge clk) begin
      #1;
      check("data",         data,                  e_data);
      check("data_valid",   {31'd0, data_valid},   {31'd0, e_valid});
      check("busy",         {31'd0, busy},         {31'd0, e_busy});
      check("load_done",    {31'd0, load_done},    {31'd0, e_done});
      check("words_loaded", {16'd0, words_loaded}, {16'd0, e_words});
      if (load_done === 1'b1) done_cnt++;
      if (busy === 1'b1)      busy_cnt++;
   end

   // --------------------------------------------------------------- stimulus
   task automatic drive_noise();
      if (noise) begin
         read_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) address = $urandom;
         else                           address = $urandom_range(0, DEPTH * 4 + 15);
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      load_start      = 1'b0;
      load_byte_valid = 1'b0;
      drive_noise();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      load_start      = 1'b0;
      load_byte_valid = 1'b1;
      load_byte       = b;
      drive_noise();
   endtask

   task automatic start_load(input int len);
      @(negedge clk);
      load_start      = 1'b1;
      load_len        = 16'(len);
      load_byte_valid = 1'b0;
      drive_noise();
   endtask

   task automatic send_word(input logic [31:0] wd, input int gap_max);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, gap_max)) idle_cycle();
         send_byte(wd[8*i +: 8]);
      end
   endtask

   task automatic wait_done(input string name, input int bound);
      int c0;
      bit seen;
      c0   = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         idle_cycle();
         if (done_cnt != c0) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd1);
   endtask

   task automatic fetch_pin(input string name, input logic [31:0] a, output logic [31:0] got);
      @(negedge clk);
      load_start      = 1'b0;
      load_byte_valid = 1'b0;
      read_en         = 1'b1;
      address         = a;
      @(posedge clk);
      #2;
      check({name, "_valid"}, {31'd0, data_valid}, 32'd1);
      got = data;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] got;
      logic [31:0] first;
      logic [7:0]  part [6];
      int          b0;
      int          d0;

      part = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h22};

      // Reset values
      repeat (3) idle_cycle();
      @(posedge clk);
      #2;
      check("rst_data",  data,                  NOP);
      check("rst_valid", {31'd0, data_valid},   32'd0);
      check("rst_busy",  {31'd0, busy},         32'd0);
      check("rst_done",  {31'd0, load_done},    32'd0);
      check("rst_words", {16'd0, words_loaded}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Fill the whole memory with random words
      noise = 1'b1;
      start_load(DEPTH);
      for (int i = 0; i < DEPTH; i++) send_word($urandom, 1);
      wait_done("full_done", 50);
      check("full_words", {16'd0, words_loaded}, 32'(DEPTH));

      // Two-word program
      repeat (3) idle_cycle();
      d0 = done_cnt;
      start_load(2);
      send_word(32'h00A0_0513, 0);
      send_word(32'h0010_0593, 2);
      wait_done("tv_done", 20);
      repeat (4) idle_cycle();
      check("tv_done_once", 32'(done_cnt - d0), 32'd1);
      check("tv_words", {16'd0, words_loaded}, 32'd2);

      // Aligned, misaligned, hold, out-of-range and top-word reads
      noise = 1'b0;
      fetch_pin("rd_aligned", 32'h0, got);
      check("rd_aligned", got, 32'h00A0_0513);
      fetch_pin("rd_misaligned", 32'h2, got);
      check("rd_misaligned", got, 32'h0593_00A0);
      @(negedge clk);
      read_en = 1'b0;
      @(posedge clk);
      #2;
      check("hold_valid", {31'd0, data_valid}, 32'd0);
      check("hold_data",  data, 32'h0593_00A0);
      fetch_pin("rd_oob", 32'(DEPTH * 4), got);
      check("rd_oob", got, NOP);
      fetch_pin("rd_last_mis", 32'((DEPTH - 1) * 4 + 2), got);
      check("rd_last_upper", {16'd0, got[31:16]}, 32'h0000_0001);

      // Zero-length load
      @(negedge clk);
      read_en = 1'b0;
      b0 = busy_cnt;
      d0 = done_cnt;
      start_load(0);
      @(posedge clk);
      #2;
      check("len0_done_next", {31'd0, load_done}, 32'd1);
      repeat (5) idle_cycle();
      check("len0_busy_cycles", 32'(busy_cnt - b0), 32'd2);
      check("len0_done_once",   32'(done_cnt - d0), 32'd1);
      fetch_pin("len0_mem0", 32'h0, got);
      check("len0_mem0", got, 32'h00A0_0513);

      // Reset after 6 bytes of a 3-word load, fetching all the while
      @(negedge clk);
      read_en = 1'b1;
      address = 32'h0;
      start_load(3);
      @(posedge clk);
      #2;
      check("ld_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         send_byte(part[i]);
         @(posedge clk);
         #2;
         check("ld_nop_data",  data, NOP);
         check("ld_nop_valid", {31'd0, data_valid}, 32'd0);
      end
      @(negedge clk);
      reset           = 1'b1;
      load_byte_valid = 1'b0;
      @(posedge clk);
      #2;
      check("rst2_busy",  {31'd0, busy},         32'd0);
      check("rst2_data",  data,                  NOP);
      check("rst2_valid", {31'd0, data_valid},   32'd0);
      check("rst2_done",  {31'd0, load_done},    32'd0);
      check("rst2_words", {16'd0, words_loaded}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      fetch_pin("rst2_mem0", 32'h0, got);
      check("rst2_mem0", got, 32'hDEAD_BEEF);
      fetch_pin("rst2_mem1", 32'h4, got);
      check("rst2_mem1", got, 32'h0010_0593);

      // Load one word more than the memory holds: last write dropped, no wrap
      noise = 1'b1;
      first = $urandom;
      start_load(DEPTH + 1);
      send_word(first, 1);
      for (int i = 1; i <= DEPTH; i++) send_word($urandom, 1);
      wait_done("ovl_done", 50);
      check("ovl_words", {16'd0, words_loaded}, 32'(DEPTH + 1));
      repeat (3) idle_cycle();
      noise = 1'b0;
      fetch_pin("ovl_nowrap", 32'h0, got);
      check("ovl_nowrap", got, first);

      // Fully random traffic, including stray starts, stray bytes and resets
      noise = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset           = ($urandom_range(0, 399) == 0);
         load_start      = ($urandom_range(0, 49) == 0);
         load_len        = 16'($urandom_range(0, 3));
         load_byte_valid = 1'($urandom_range(0, 1));
         load_byte       = 8'($urandom);
         drive_noise();
      end
      @(negedge clk);
      reset           = 1'b0;
      load_start      = 1'b0;
      load_byte_valid = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
